// File: rtl/d3s_lut_interp_pkg.sv
// Shared defaults, dither LFSR definition and per-lane seeding for the D3S LUT interpolator.
// Fraction width is always derived as phase_bits-1-lut_size_log2 and must be at least 1.
package d3s_lut_interp_pkg;

    localparam int C_NUM_CHANNELS  = 4;
    localparam int C_PHASE_BITS    = 14;
    localparam int C_LUT_SIZE_LOG2 = 10;
    localparam int C_SAMPLE_BITS   = 18;
    localparam int C_SLOPE_BITS    = 18;
    localparam int C_OUTPUT_BITS   = 14;

    localparam int          LFSR_W         = 16;
    localparam logic [15:0] LFSR_SEED_BASE = 16'hACE1;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_seed(input int lane);
        logic [LFSR_W-1:0] s;
        s = LFSR_SEED_BASE ^ (16'(lane) * 16'h1357);
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/d3s_lut_interp_lane.sv
// One lane: phase register, LUT data capture, slope*frac, interpolate/dither/saturate/offset.
// Latency: 4 clk from phase_vld to dac_vld (LUT read register lives in the parent's RAM).
// Backpressure: none; a new phase may be accepted every cycle.
module d3s_lut_interp_lane
    import d3s_lut_interp_pkg::*;
#(
    parameter int g_lane          = 0,
    parameter int g_phase_bits    = C_PHASE_BITS,
    parameter int g_lut_size_log2 = C_LUT_SIZE_LOG2,
    parameter int g_sample_bits   = C_SAMPLE_BITS,
    parameter int g_slope_bits    = C_SLOPE_BITS,
    parameter int g_output_bits   = C_OUTPUT_BITS
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [g_phase_bits-1:0]               phase_dat,
    input  logic                                  phase_vld,
    input  logic                                  interp_en,
    input  logic                                  dither_en,
    output logic [g_lut_size_log2-1:0]            rd_addr,
    input  logic [g_slope_bits+g_sample_bits-1:0] rd_dat,
    output logic [g_output_bits-1:0]              dac_dat,
    output logic                                  dac_vld
);

    localparam int F  = g_phase_bits - 1 - g_lut_size_log2;
    localparam int D  = g_sample_bits - g_output_bits;
    localparam int PW = g_slope_bits + F;
    localparam int W  = ((g_sample_bits > g_slope_bits) ? g_sample_bits : g_slope_bits) + 2;
    localparam int S  = g_sample_bits;
    localparam int O  = g_output_bits;
    localparam logic [O-1:0] MID      = {1'b1, {(O-1){1'b0}}};
    localparam logic [O-1:0] HALF_MAX = {1'b0, {(O-1){1'b1}}};

    logic [g_phase_bits-1:0] s1_phase;
    logic                    s1_vld, s1_interp, s1_dither;
    logic [F-1:0]            s2_frac;
    logic                    s2_vld, s2_sign, s2_interp, s2_dither;
    logic signed [PW-1:0]    s3_prod;
    logic [S-1:0]            s3_sample;
    logic                    s3_vld, s3_sign, s3_interp, s3_dither;
    logic [LFSR_W-1:0]       lfsr;
    logic signed [g_slope_bits-1:0] slope;

    logic signed [W-1:0] interp_term, sum;
    logic [S-1:0]        mag, mag_d;
    logic [S:0]          dith;
    logic [D-1:0]        dith_add;
    logic [O-1:0]        shifted, sat, out_dat;

    assign rd_addr = s1_phase[g_phase_bits-2 -: g_lut_size_log2];
    assign slope   = $signed(rd_dat[g_slope_bits+S-1:S]);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_phase  <= '0;
            s1_vld    <= 1'b0;
            s1_interp <= 1'b0;
            s1_dither <= 1'b0;
            s2_frac   <= '0;
            s2_vld    <= 1'b0;
            s2_sign   <= 1'b0;
            s2_interp <= 1'b0;
            s2_dither <= 1'b0;
            s3_prod   <= '0;
            s3_sample <= '0;
            s3_vld    <= 1'b0;
            s3_sign   <= 1'b0;
            s3_interp <= 1'b0;
            s3_dither <= 1'b0;
        end else begin
            s1_phase  <= phase_dat;
            s1_vld    <= phase_vld;
            s1_interp <= interp_en;
            s1_dither <= dither_en;
            // rd_dat is registered by the LUT on this same edge, so S2 holds the controls only
            s2_frac   <= s1_phase[F-1:0];
            s2_sign   <= s1_phase[g_phase_bits-1];
            s2_vld    <= s1_vld;
            s2_interp <= s1_interp;
            s2_dither <= s1_dither;
            s3_prod   <= PW'(slope) * PW'($signed({1'b0, s2_frac}));
            s3_sample <= rd_dat[S-1:0];
            s3_sign   <= s2_sign;
            s3_vld    <= s2_vld;
            s3_interp <= s2_interp;
            s3_dither <= s2_dither;
        end
    end

    always_comb begin
        interp_term = s3_interp ? W'(s3_prod >>> F) : '0;
        sum         = $signed(W'(s3_sample)) + interp_term;
        if (sum[W-1])
            mag = '0;
        else if (|sum[W-2:S])
            mag = '1;
        else
            mag = sum[S-1:0];
        dith_add = s3_dither ? lfsr[D-1:0] : '0;
        dith     = {1'b0, mag} + (S+1)'(dith_add);
        mag_d    = dith[S] ? '1 : dith[S-1:0];
        shifted  = mag_d[S-1:D];
        sat      = shifted[O-1] ? HALF_MAX : shifted;
        out_dat  = s3_sign ? (MID - sat) : (MID + sat);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dac_dat <= MID;
            dac_vld <= 1'b0;
            lfsr    <= lfsr_seed(g_lane);
        end else begin
            dac_vld <= s3_vld;
            if (s3_vld) begin
                dac_dat <= out_dat;
                lfsr    <= lfsr_next(lfsr);
            end
        end
    end

endmodule

// File: rtl/d3s_lut_interp.sv
// N-lane half-wave LUT phase-to-amplitude converter with interpolation, dither and saturation.
// Latency: 4 clk from phase_valid_i to dac_valid_o; output holds between valid samples.
// Backpressure: none; accepts a phase set every cycle and LUT writes never stall the datapath.
module d3s_lut_interp
    import d3s_lut_interp_pkg::*;
#(
    parameter int g_num_channels  = C_NUM_CHANNELS,
    parameter int g_phase_bits    = C_PHASE_BITS,
    parameter int g_lut_size_log2 = C_LUT_SIZE_LOG2,
    parameter int g_sample_bits   = C_SAMPLE_BITS,
    parameter int g_slope_bits    = C_SLOPE_BITS,
    parameter int g_output_bits   = C_OUTPUT_BITS
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n_i,
    input  logic [g_num_channels*g_phase_bits-1:0]   phase_divided_i,
    input  logic                                     phase_valid_i,
    input  logic                                     interp_en_i,
    input  logic                                     dither_en_i,
    input  logic                                     lut_wr_i,
    input  logic [g_lut_size_log2-1:0]               lut_addr_i,
    input  logic [g_slope_bits+g_sample_bits-1:0]    lut_data_i,
    output logic [g_num_channels*g_output_bits-1:0]  dac_data_par_o,
    output logic                                     dac_valid_o
);

    localparam int E     = g_slope_bits + g_sample_bits;
    localparam int NPAIR = (g_num_channels + 1) / 2;

    logic [g_num_channels-1:0][g_lut_size_log2-1:0] rd_addr;
    logic [g_num_channels-1:0][E-1:0]               rd_dat;
    logic [g_num_channels-1:0]                      lane_vld;

    // LUT contents are not reset; firmware loads them through the write port.
    for (genvar p = 0; p < NPAIR; p++) begin : g_pair
        logic [E-1:0] mem [1 << g_lut_size_log2];
        logic [E-1:0] rd_a;

        always_ff @(posedge clk_i) begin
            if (lut_wr_i)
                mem[lut_addr_i] <= lut_data_i;
            rd_a <= mem[rd_addr[2*p]];
        end
        assign rd_dat[2*p] = rd_a;

        if (2*p + 1 < g_num_channels) begin : g_second
            logic [E-1:0] rd_b;
            always_ff @(posedge clk_i)
                rd_b <= mem[rd_addr[2*p+1]];
            assign rd_dat[2*p+1] = rd_b;
        end
    end

    for (genvar k = 0; k < g_num_channels; k++) begin : g_lane
        d3s_lut_interp_lane #(
            .g_lane          (k),
            .g_phase_bits    (g_phase_bits),
            .g_lut_size_log2 (g_lut_size_log2),
            .g_sample_bits   (g_sample_bits),
            .g_slope_bits    (g_slope_bits),
            .g_output_bits   (g_output_bits)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .phase_dat (phase_divided_i[k*g_phase_bits +: g_phase_bits]),
            .phase_vld (phase_valid_i),
            .interp_en (interp_en_i),
            .dither_en (dither_en_i),
            .rd_addr   (rd_addr[k]),
            .rd_dat    (rd_dat[k]),
            .dac_dat   (dac_data_par_o[k*g_output_bits +: g_output_bits]),
            .dac_vld   (lane_vld[k])
        );
    end

    assign dac_valid_o = &lane_vld;

endmodule

// File: tb/tb_d3s_lut_interp.sv
// Directed bench for d3s_lut_interp: hand-computed vectors for latency, interpolation,
// saturation, LUT write ordering, valid gaps, async reset and dither statistics.
module tb_d3s_lut_interp;

    localparam int N  = 4;
    localparam int P  = 14;
    localparam int L  = 10;
    localparam int S  = 18;
    localparam int SL = 18;
    localparam int O  = 14;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [N*P-1:0]    phase_divided_i;
    logic              phase_valid_i;
    logic              interp_en_i;
    logic              dither_en_i;
    logic              lut_wr_i;
    logic [L-1:0]      lut_addr_i;
    logic [SL+S-1:0]   lut_data_i;
    logic [N*O-1:0]    dac_data_par_o;
    logic              dac_valid_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    d3s_lut_interp dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .phase_divided_i (phase_divided_i),
        .phase_valid_i   (phase_valid_i),
        .interp_en_i     (interp_en_i),
        .dither_en_i     (dither_en_i),
        .lut_wr_i        (lut_wr_i),
        .lut_addr_i      (lut_addr_i),
        .lut_data_i      (lut_data_i),
        .dac_data_par_o  (dac_data_par_o),
        .dac_valid_o     (dac_valid_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [N*P-1:0] ph4(input logic [P-1:0] ph);
        return {N{ph}};
    endfunction

    function automatic logic [N*O-1:0] out4(input logic [O-1:0] v);
        return {N{v}};
    endfunction

    task automatic lut_write(input logic [L-1:0] addr, input logic [SL+S-1:0] data);
        lut_addr_i = addr;
        lut_data_i = data;
        lut_wr_i   = 1'b1;
        tick(1);
        lut_wr_i   = 1'b0;
    endtask

    // One valid phase set, then confirm it emerges exactly 4 clocks later and holds after.
    task automatic sample_check(input string tag, input logic [N*P-1:0] bus,
                                input logic interp, input logic [N*O-1:0] exp);
        phase_divided_i = bus;
        interp_en_i     = interp;
        phase_valid_i   = 1'b1;
        tick(1);
        phase_valid_i   = 1'b0;
        tick(2);
        check({tag, "_vld_early"}, 64'(dac_valid_o), 64'd0);
        tick(1);
        check({tag, "_vld"}, 64'(dac_valid_o), 64'd1);
        check({tag, "_dat"}, 64'(dac_data_par_o), 64'(exp));
        tick(1);
        check({tag, "_vld_drop"}, 64'(dac_valid_o), 64'd0);
        check({tag, "_hold"}, 64'(dac_data_par_o), 64'(exp));
    endtask

    // Continuous dithered stream; count outputs at base+1 and anything outside {base, base+1}.
    task automatic dither_run(input string tag, input logic [P-1:0] ph, input logic [O-1:0] base,
                              input int hi_min, input int hi_max);
        int hi  [N];
        int bad [N];
        logic [O-1:0] v;
        for (int k = 0; k < N; k++) begin
            hi[k]  = 0;
            bad[k] = 0;
        end
        phase_divided_i = ph4(ph);
        interp_en_i     = 1'b1;
        dither_en_i     = 1'b1;
        phase_valid_i   = 1'b1;
        tick(4);
        for (int i = 0; i < 4096; i++) begin
            for (int k = 0; k < N; k++) begin
                v = dac_data_par_o[k*O +: O];
                if (v == base + 14'd1)
                    hi[k]++;
                else if (v != base || !dac_valid_o)
                    bad[k]++;
            end
            tick(1);
        end
        phase_valid_i = 1'b0;
        dither_en_i   = 1'b0;
        tick(4);
        for (int k = 0; k < N; k++) begin
            check({tag, "_outside_set"}, 64'(bad[k]), 64'd0);
            check({tag, "_mean_window"}, 64'(hi[k] >= hi_min && hi[k] <= hi_max), 64'd1);
        end
    endtask

    initial begin
        rst_n_i         = 1'b0;
        phase_divided_i = '0;
        phase_valid_i   = 1'b0;
        interp_en_i     = 1'b1;
        dither_en_i     = 1'b0;
        lut_wr_i        = 1'b0;
        lut_addr_i      = '0;
        lut_data_i      = '0;
        tick(3);
        check("reset_dat", 64'(dac_data_par_o), 64'(out4(14'h2000)));
        check("reset_vld", 64'(dac_valid_o), 64'd0);
        rst_n_i = 1'b1;
        tick(2);
        check("idle_vld", 64'(dac_valid_o), 64'd0);

        lut_write(10'd100, {18'h00800, 18'h10000});
        lut_write(10'd7,   {18'h00000, 18'h3FFFF});
        lut_write(10'd200, {18'h3F000, 18'h20000});
        lut_write(10'd201, {18'h20000, 18'h00100});
        lut_write(10'd300, {18'h00000, 18'h10008});

        sample_check("idx100_pos",   ph4(14'h0320), 1'b1, out4(14'h3000));
        sample_check("idx100_neg",   ph4(14'h2320), 1'b1, out4(14'h1000));
        sample_check("frac4_interp", ph4(14'h0324), 1'b1, out4(14'h3040));
        sample_check("frac4_trunc",  ph4(14'h0324), 1'b0, out4(14'h3000));
        sample_check("lane_mix",
                     {14'h2324, 14'h0324, 14'h2320, 14'h0320}, 1'b1,
                     {14'h0FC0, 14'h3040, 14'h1000, 14'h3000});
        sample_check("sat_pos",      ph4(14'h0038), 1'b1, out4(14'h3FFF));
        sample_check("sat_neg",      ph4(14'h2038), 1'b1, out4(14'h0001));
        sample_check("neg_slope",    ph4(14'h0647), 1'b1, out4(14'h3F20));
        sample_check("neg_slope_tr", ph4(14'h0647), 1'b0, out4(14'h3FFF));
        sample_check("clamp_zero",   ph4(14'h064F), 1'b1, out4(14'h2000));
        sample_check("clamp_off",    ph4(14'h064F), 1'b0, out4(14'h2010));

        // Read racing a write of the same entry: first sample sees old data, second sees new.
        lut_write(10'd50, {18'h00000, 18'h08000});
        phase_divided_i = ph4(14'h0190);
        interp_en_i     = 1'b1;
        phase_valid_i   = 1'b1;
        tick(1);
        lut_addr_i = 10'd50;
        lut_data_i = {18'h00000, 18'h0C000};
        lut_wr_i   = 1'b1;
        tick(1);
        lut_wr_i      = 1'b0;
        phase_valid_i = 1'b0;
        tick(2);
        check("wr_race_old", 64'(dac_data_par_o), 64'(out4(14'h2800)));
        tick(1);
        check("wr_race_new", 64'(dac_data_par_o), 64'(out4(14'h2C00)));
        check("wr_race_vld", 64'(dac_valid_o), 64'd1);
        tick(2);

        // Valid pattern 1,0,1 with a garbage phase in the gap.
        phase_divided_i = ph4(14'h0320);
        phase_valid_i   = 1'b1;
        tick(1);
        phase_divided_i = ph4(14'h0038);
        phase_valid_i   = 1'b0;
        tick(1);
        phase_divided_i = ph4(14'h2320);
        phase_valid_i   = 1'b1;
        tick(1);
        phase_valid_i   = 1'b0;
        tick(1);
        check("gap_vld_a", 64'(dac_valid_o), 64'd1);
        check("gap_dat_a", 64'(dac_data_par_o), 64'(out4(14'h3000)));
        tick(1);
        check("gap_vld_b", 64'(dac_valid_o), 64'd0);
        check("gap_hold",  64'(dac_data_par_o), 64'(out4(14'h3000)));
        tick(1);
        check("gap_vld_c", 64'(dac_valid_o), 64'd1);
        check("gap_dat_c", 64'(dac_data_par_o), 64'(out4(14'h1000)));
        tick(2);

        // Asynchronous reset in the middle of a continuous stream.
        phase_divided_i = ph4(14'h0324);
        phase_valid_i   = 1'b1;
        tick(8);
        check("pre_rst_dat", 64'(dac_data_par_o), 64'(out4(14'h3040)));
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_rst_dat", 64'(dac_data_par_o), 64'(out4(14'h2000)));
        check("async_rst_vld", 64'(dac_valid_o), 64'd0);
        phase_valid_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("post_rst_vld", 64'(dac_valid_o), 64'd0);
        end
        check("post_rst_dat", 64'(dac_data_par_o), 64'(out4(14'h2000)));

        // Ideal 0x3040 exactly: dither never carries, at most half the samples may round up.
        dither_run("dither_exact", 14'h0324, 14'h3040, 0, 2048);
        // Ideal 0x3000.5: roughly half the samples should round up.
        dither_run("dither_half", 14'h0960, 14'h3000, 1700, 2400);
        sample_check("dither_off", ph4(14'h0960), 1'b1, out4(14'h3000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
